// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches, JAL and JALR into taken/target/link, with alignment and illegal-op flags plus branch stats.
// Latency: 1 cycle from accept to out_valid, full throughput.
// Backpressure: in_ready = !out_valid || out_ready; the result register holds while out_valid && !out_ready.
module branch_resolve_unit #(
    parameter int XLEN    = 32,
    parameter int IALIGN  = 32,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_branch,
    input  logic               is_jal,
    input  logic               is_jalr,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    rs1,
    input  logic [XLEN-1:0]    rs2,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_taken,
    output logic [XLEN-1:0]    out_target,
    output logic [XLEN-1:0]    out_link,
    output logic               out_illegal,
    output logic               out_misaligned,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] cnt_branches,
    output logic [COUNT_W-1:0] cnt_taken
);

    localparam bit CHECK_BIT1 = (IALIGN == 32);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic            accept;
    logic [XLEN-1:0] link_n, pc_rel, jalr_sum, target_n;
    logic            eq, lt_s, lt_u;
    logic            cond, legal;
    logic            taken_n, illegal_n, misaligned_n;
    logic            count_branch;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign link_n   = pc + XLEN'(4);
    assign pc_rel   = pc + imm;
    assign jalr_sum = rs1 + imm;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = !lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = !lt_u;
            default: legal = 1'b0;
        endcase
    end

    // JALR wins over JAL, which wins over a conditional branch; no op falls through to pc+4.
    always_comb begin
        taken_n   = 1'b0;
        target_n  = link_n;
        illegal_n = 1'b0;
        if (is_jalr) begin
            taken_n  = 1'b1;
            target_n = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_jal) begin
            taken_n  = 1'b1;
            target_n = pc_rel;
        end else if (is_branch) begin
            illegal_n = !legal;
            taken_n   = legal && cond;
            if (legal && cond) begin
                target_n = pc_rel;
            end
        end
    end

    assign misaligned_n = CHECK_BIT1 && taken_n && target_n[1];
    assign count_branch = accept && is_branch && !is_jal && !is_jalr && legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_link       <= '0;
            out_illegal    <= 1'b0;
            out_misaligned <= 1'b0;
            cnt_branches   <= '0;
            cnt_taken      <= '0;
        end else begin
            if (accept) begin
                out_valid      <= 1'b1;
                out_taken      <= taken_n;
                out_target     <= target_n;
                out_link       <= link_n;
                out_illegal    <= illegal_n;
                out_misaligned <= misaligned_n;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Clear beats a same-cycle increment; counters stick at all-ones.
            if (cnt_clr) begin
                cnt_branches <= '0;
                cnt_taken    <= '0;
            end else if (count_branch) begin
                if (cnt_branches != CNT_MAX) begin
                    cnt_branches <= cnt_branches + COUNT_W'(1);
                end
                if (taken_n && cnt_taken != CNT_MAX) begin
                    cnt_taken <= cnt_taken + COUNT_W'(1);
                end
            end
        end
    end

endmodule
